// File: rtl/mmio_pkg.sv
// Shared register map, STATUS bit positions and timer width for the MMIO controller.
package mmio_pkg;

  typedef enum logic [10:0] {
    OFF_TX_DATA  = 11'h000,
    OFF_STATUS   = 11'h001,
    OFF_RX_DATA  = 11'h002,
    OFF_TIMER_LO = 11'h003,
    OFF_TIMER_HI = 11'h004,
    OFF_IRQ_EN   = 11'h005
  } reg_off_e;

  localparam int unsigned ST_TX_EMPTY     = 0;
  localparam int unsigned ST_TX_FULL      = 1;
  localparam int unsigned ST_RX_NONEMPTY  = 2;
  localparam int unsigned ST_RX_FULL      = 3;
  localparam int unsigned ST_TX_OVF       = 4;
  localparam int unsigned ST_TX_COUNT_LSB = 8;
  localparam int unsigned ST_RX_COUNT_LSB = 12;

  localparam int unsigned TIMER_WIDTH = 32;

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full are dropped, pops while empty ignored.
module mmio_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the pre-edge count, so a full FIFO drops a push even alongside a pop.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO window controller: TX/RX FIFOs, strobe-tick timer with snapshot, STATUS register.
// Optional interrupt output and IRQ_EN register when MMIO_IRQ_EN is defined.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE  = 16'hF800,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_stb_800k,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_wdata,
  input  logic        mem_write_en,
  output logic        mmio_sel,
  output logic [15:0] mmio_rdata,
  output logic        ram_write_en,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef MMIO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [10:0]            off;
  logic                   wr;
  logic [CW-1:0]          tx_count, rx_count;
  logic                   tx_full, tx_empty, rx_full, rx_empty;
  logic [15:0]            rx_head;
  logic                   tx_ovf;
  logic [TIMER_WIDTH-1:0] timer_cnt, timer_snap;
  logic [15:0]            status;

  assign off          = data_addr[10:0];
  assign mmio_sel     = (data_addr[15:11] == MMIO_BASE[15:11]);
  assign ram_write_en = mem_write_en & ~mmio_sel;
  assign wr           = mem_write_en & clk_stb_800k & mmio_sel;
  assign tx_valid     = ~tx_empty;
  assign rx_ready     = ~rx_full;

  mmio_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr && off == OFF_TX_DATA),
    .pop   (tx_valid & tx_ready),
    .wdata (data_wdata),
    .rdata (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  mmio_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid & rx_ready),
    .pop   (wr && off == OFF_RX_DATA),
    .wdata (rx_data),
    .rdata (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Snapshot samples the pre-increment counter when a tick and a capture share an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_cnt  <= '0;
      timer_snap <= '0;
      tx_ovf     <= 1'b0;
    end else begin
      if (clk_stb_800k) timer_cnt <= timer_cnt + 1'b1;
      if (wr && off == OFF_TIMER_LO) timer_snap <= timer_cnt;
      if (wr && off == OFF_TX_DATA && tx_full) tx_ovf <= 1'b1;
      else if (wr && off == OFF_STATUS)        tx_ovf <= 1'b0;
    end
  end

`ifdef MMIO_IRQ_EN
  logic [1:0] irq_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr && off == OFF_IRQ_EN) irq_en <= data_wdata[1:0];
      irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
    end
  end
`endif

  always_comb begin
    status                          = '0;
    status[ST_TX_EMPTY]             = tx_empty;
    status[ST_TX_FULL]              = tx_full;
    status[ST_RX_NONEMPTY]          = ~rx_empty;
    status[ST_RX_FULL]              = rx_full;
    status[ST_TX_OVF]               = tx_ovf;
    status[ST_TX_COUNT_LSB +: 4]    = 4'(tx_count);
    status[ST_RX_COUNT_LSB +: 4]    = 4'(rx_count);
  end

  always_comb begin
    mmio_rdata = '0;
    if (mmio_sel) begin
      case (off)
        OFF_STATUS:   mmio_rdata = status;
        OFF_RX_DATA:  mmio_rdata = rx_head;
        OFF_TIMER_LO: mmio_rdata = timer_snap[15:0];
        OFF_TIMER_HI: mmio_rdata = timer_snap[31:16];
`ifdef MMIO_IRQ_EN
        OFF_IRQ_EN:   mmio_rdata = {14'b0, irq_en};
`endif
        default:      mmio_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with a queue scoreboard for TX/RX word ordering.
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_stb_800k = 1'b0;
  logic [15:0] data_addr = '0;
  logic [15:0] data_wdata = '0;
  logic        mem_write_en = 1'b0;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        mmio_sel, ram_write_en, tx_valid, rx_ready;
  logic [15:0] mmio_rdata, tx_data;
`ifdef MMIO_IRQ_EN
  logic        irq;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  bit          ovf_m = 1'b0;

  mmio_ctrl #(.MMIO_BASE(16'hF800), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_stb_800k (clk_stb_800k),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .mem_write_en (mem_write_en),
    .mmio_sel     (mmio_sel),
    .mmio_rdata   (mmio_rdata),
    .ram_write_en (ram_write_en),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
`ifdef MMIO_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] status_model();
    logic [15:0] s;
    s        = '0;
    s[0]     = (tx_q.size() == 0);
    s[1]     = (tx_q.size() == 8);
    s[2]     = (rx_q.size() != 0);
    s[3]     = (rx_q.size() == 8);
    s[4]     = ovf_m;
    s[11:8]  = 4'(tx_q.size());
    s[15:12] = 4'(rx_q.size());
    return s;
  endfunction

  task automatic rd(input logic [15:0] addr, input string tag, input logic [15:0] exp);
    data_addr = addr;
    #1;
    check(tag, {16'h0, mmio_rdata}, {16'h0, exp});
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] d);
    @(negedge clk);
    data_addr    = addr;
    data_wdata   = d;
    mem_write_en = 1'b1;
    clk_stb_800k = 1'b1;
    @(negedge clk);
    mem_write_en = 1'b0;
    clk_stb_800k = 1'b0;
    data_addr    = '0;
    case (addr)
      16'hF800: if (tx_q.size() < 8) tx_q.push_back(d); else ovf_m = 1'b1;
      16'hF801: ovf_m = 1'b0;
      16'hF802: if (rx_q.size() > 0) void'(rx_q.pop_front());
      default: ;
    endcase
  endtask

  task automatic rx_push(input logic [15:0] d);
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (rx_q.size() < 8) rx_q.push_back(d);
  endtask

  task automatic tx_drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      check("tx_valid_drain", {31'h0, tx_valid}, 32'h1);
      check("tx_data_order", {16'h0, tx_data}, {16'h0, tx_q.pop_front()});
    end
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    rx_q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_tx_data", {16'h0, tx_data}, 32'h0);
    rd(16'hF801, "rst_status", 16'h0001);
    rd(16'hF803, "rst_timer_lo", 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // 1: three TX pushes, then drain in order
    cpu_write(16'hF800, 16'h1111);
    cpu_write(16'hF800, 16'h2222);
    cpu_write(16'hF800, 16'h3333);
    rd(16'hF801, "t1_status3", 16'h0300);
    check("t1_tx_head", {16'h0, tx_data}, 32'h1111);
    rd(16'hF800, "t1_txdata_reads0", 16'h0000);
    tx_drain(3);
    rd(16'hF801, "t1_status_empty", 16'h0001);

    // 2: overflow on 9th push, STATUS write clears tx_ovf
    for (int unsigned i = 0; i < 9; i++) cpu_write(16'hF800, 16'(16'h0A00 + i));
    rd(16'hF801, "t2_status_ovf", 16'h0812);
    rd(16'hF801, "t2_status_model", status_model());
    cpu_write(16'hF801, 16'h0000);
    rd(16'hF801, "t2_status_clr", 16'h0802);
    tx_drain(8);
    rd(16'hF801, "t2_status_drained", 16'h0001);

    // 3: RX ordering, pop, fill to full
    rx_push(16'hAAAA);
    rx_push(16'hBBBB);
    rd(16'hF802, "t3_rx_head_a", 16'hAAAA);
    rd(16'hF801, "t3_status_rx2", 16'h2005);
    cpu_write(16'hF802, 16'h0000);
    rd(16'hF802, "t3_rx_head_b", 16'hBBBB);
    for (int unsigned i = 0; i < 7; i++) rx_push(16'(16'hC000 + i));
    #1;
    check("t3_rx_ready_full", {31'h0, rx_ready}, 32'h0);
    rx_push(16'hDEAD);
    rd(16'hF801, "t3_status_full", 16'h800D);
    for (int unsigned i = 0; i < 8; i++) begin
      rd(16'hF802, "t3_rx_drain", rx_q[0]);
      cpu_write(16'hF802, 16'h0000);
    end
    rd(16'hF802, "t3_rx_empty_reads0", 16'h0000);
    cpu_write(16'hF802, 16'h0000);
    rd(16'hF801, "t3_status_after_pop_empty", 16'h0001);

    // 4: timer snapshot after 1000 ticks
    reset_pulse();
    clk_stb_800k = 1'b1;
    repeat (1000) @(negedge clk);
    clk_stb_800k = 1'b0;
    cpu_write(16'hF803, 16'h0000);
    rd(16'hF803, "t4_timer_lo", 16'h03E8);
    rd(16'hF804, "t4_timer_hi", 16'h0000);
    cpu_write(16'hF804, 16'hFFFF);
    rd(16'hF803, "t4_hi_write_ignored", 16'h03E8);

    // 5: address decode and write gating
    @(negedge clk);
    data_addr = 16'hF7FF;
    mem_write_en = 1'b1;
    #1;
    check("t5_ram_we_out", {31'h0, ram_write_en}, 32'h1);
    check("t5_sel_out", {31'h0, mmio_sel}, 32'h0);
    data_addr = 16'hF800;
    data_wdata = 16'hBEEF;
    #1;
    check("t5_ram_we_in", {31'h0, ram_write_en}, 32'h0);
    check("t5_sel_in", {31'h0, mmio_sel}, 32'h1);
    @(negedge clk);
    mem_write_en = 1'b0;
    #1;
    check("t5_no_stb_tx_valid", {31'h0, tx_valid}, 32'h0);
    rd(16'hF801, "t5_no_stb_status", 16'h0001);
    rd(16'h1234, "t5_unsel_rdata", 16'h0000);
    rd(16'hF8FF, "t5_unmapped", 16'h0000);
`ifndef MMIO_IRQ_EN
    rd(16'hF805, "t5_irq_en_unmapped", 16'h0000);
`endif

    // 6: asynchronous reset with queued traffic
    for (int unsigned i = 0; i < 5; i++) cpu_write(16'hF800, 16'(16'h5000 + i));
    rx_push(16'h7001);
    rx_push(16'h7002);
    rd(16'hF801, "t6_status_loaded", 16'h2504);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("t6_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("t6_rst_tx_data", {16'h0, tx_data}, 32'h0);
    tx_q.delete();
    rx_q.delete();
    ovf_m = 1'b0;
    rd(16'hF801, "t6_rst_status", 16'h0001);
    @(negedge clk);
    rst = 1'b1;

`ifdef MMIO_IRQ_EN
    cpu_write(16'hF805, 16'hFFFD);
    rd(16'hF805, "t6_irq_en_read", 16'h0001);
    check("t6_irq_idle", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rx_data  = 16'h0042;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t6_irq_same_edge", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t6_irq_next_clk", {31'h0, irq}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
